l3_victim_select: RTL and testbench

- Replacement and way-selection stage directly downstream of the L3 tag array.
- Consumes one set's lookup result: per-way hit, valid and dirty vectors plus the set index.
- Returns the way to use: the hit way on a hit; otherwise the first invalid way, falling back to a tree-PLRU victim.
- Flags whether the chosen victim needs write-back. Holds per-set tree-PLRU state and supports a whole-cache PLRU flush.

---
 rtl/l3_cache_pkg.sv | 76 +++++++
 rtl/l3_plru_ram.sv | 40 ++++
 rtl/l3_victim_select.sv | 201 ++++++++++++++++++++
 tb/tb_l3_victim_select.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/l3_cache_pkg.sv
// ---------------------------------------------------------------------------
// l3_cache_pkg
// Shared types and helpers for the L3 way-selection logic.
//   - L3_WAYS / L3_INDEX_WIDTH : default geometry (16 ways, 4096 sets)
//   - L3_PLRU_W                : tree-PLRU bits per set (ways - 1)
//   - vs_state_e               : victim-select FSM states
//   - plru_victim / plru_update: tree-PLRU walk and update (heap numbering)
//   - lowest_set               : lowest-set-bit priority encoder
// The helpers work on MAX_WAYS-wide vectors and take the real associativity
// as an argument, so one package serves any power-of-two WAYS up to 64.
// ---------------------------------------------------------------------------
package l3_cache_pkg;

  localparam int unsigned L3_WAYS        = 16;
  localparam int unsigned L3_INDEX_WIDTH = 12;
  localparam int unsigned L3_PLRU_W      = L3_WAYS - 1;

  localparam int MAX_WAYS  = 64;
  localparam int WAY_IDX_W = 6;

  typedef logic [MAX_WAYS-1:0]  way_vec_t;
  typedef logic [MAX_WAYS-2:0]  plru_vec_t;
  typedef logic [WAY_IDX_W-1:0] way_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_RESP   = 2'd2,
    ST_FLUSH  = 2'd3
  } vs_state_e;

  // Node n lives in bit n-1. Leaves are nodes ways..2*ways-1.
  function automatic way_idx_t plru_victim(input plru_vec_t bits, input int unsigned ways);
    int unsigned node;
    way_idx_t    nidx;
    node = 1;
    nidx = '0;
    for (int lvl = 0; lvl < WAY_IDX_W; lvl++) begin
      if (node < ways) begin
        nidx = way_idx_t'(node - 1);
        node = 2 * node + {31'd0, bits[nidx]};
      end
    end
    return way_idx_t'(node - ways);
  endfunction

  // Walk from the leaf to the root; each parent points to the sibling
  // subtree (1 when we came from the left child, 0 from the right).
  function automatic plru_vec_t plru_update(input plru_vec_t bits, input way_idx_t way,
                                            input int unsigned ways);
    plru_vec_t   res;
    int unsigned node;
    way_idx_t    nidx;
    res  = bits;
    node = ways + {26'd0, way};
    nidx = '0;
    for (int lvl = 0; lvl < WAY_IDX_W; lvl++) begin
      if (node > 1) begin
        nidx      = way_idx_t'((node >> 1) - 1);
        res[nidx] = ~node[0];
        node      = node >> 1;
      end
    end
    return res;
  endfunction

  function automatic way_idx_t lowest_set(input way_vec_t vec);
    way_idx_t idx;
    idx = '0;
    for (int i = MAX_WAYS - 1; i >= 0; i--) begin
      if (vec[i]) idx = way_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/l3_plru_ram.sv
// ---------------------------------------------------------------------------
// l3_plru_ram
// SETS x DATA_W PLRU state storage. Kept as its own block so it can be
// swapped for an SRAM macro later.
//   clk, rst_n          : clock, async active-low reset (clears all entries)
//   rd_idx / rd_data    : combinational read port
//   wr_en/wr_idx/wr_data: write port
//   clr_en / clr_idx    : flush path, writes zero; wins over the write port
// ---------------------------------------------------------------------------
module l3_plru_ram #(
  parameter int unsigned SETS   = 4096,
  parameter int unsigned IDX_W  = 12,
  parameter int unsigned DATA_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_en,
  input  logic [IDX_W-1:0]  clr_idx
);

  logic [DATA_W-1:0] mem [SETS];

  assign rd_data = mem[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SETS); i++) mem[i] <= '0;
    end else if (clr_en) begin
      mem[clr_idx] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/l3_victim_select.sv
// ---------------------------------------------------------------------------
// l3_victim_select
// Way selection downstream of the L3 tag array: hit way, else first invalid
// way, else tree-PLRU victim. Reports whether the victim needs write-back and
// keeps per-set PLRU state, which can be swept clear by a flush.
//   clk, rst_n                         : clock, async active-low reset
//   req_valid/req_ready                : lookup-result handshake
//   req_index, req_hit,
//   req_valid_vec, req_dirty_vec       : set index and per-way vectors
//   resp_valid/resp_ready              : selection-result handshake
//   resp_way, resp_hit,
//   resp_evict_dirty                   : one-hot way, hit flag, write-back flag
//   multi_hit_err                      : pulse when more than one way hit
//   flush_req, flush_busy, flush_done  : PLRU flush control/status
// Accept at T -> SELECT at T+1 -> resp_valid at T+2.
// ---------------------------------------------------------------------------
module l3_victim_select
  import l3_cache_pkg::*;
#(
  parameter int unsigned WAYS        = L3_WAYS,
  parameter int unsigned INDEX_WIDTH = L3_INDEX_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [INDEX_WIDTH-1:0] req_index,
  input  logic [WAYS-1:0]        req_hit,
  input  logic [WAYS-1:0]        req_valid_vec,
  input  logic [WAYS-1:0]        req_dirty_vec,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [WAYS-1:0]        resp_way,
  output logic                   resp_hit,
  output logic                   resp_evict_dirty,
  output logic                   multi_hit_err,
  input  logic                   flush_req,
  output logic                   flush_busy,
  output logic                   flush_done
);

  localparam int unsigned SETS = 2 ** INDEX_WIDTH;
  localparam int unsigned PW   = WAYS - 1;

  vs_state_e              state, state_n;
  logic                   flush_pending, flush_pending_n;
  logic [INDEX_WIDTH-1:0] flush_cnt;
  logic                   cnt_last;
  logic                   accept, in_select;

  logic [INDEX_WIDTH-1:0] idx_p0;
  logic [WAYS-1:0]        hit_p0, valid_p0, dirty_p0;

  logic [PW-1:0]          plru_rd, plru_wr;
  way_vec_t               hit_ext, free_ext;
  plru_vec_t              plru_ext;
  way_idx_t               way_idx;
  logic [WAYS-1:0]        way_oh;
  logic                   hit_any, multi_hit, evict_dirty;

  logic [WAYS-1:0]        way_p1;
  logic                   hit_flag_p1, evict_p1;

  // Equality compare on the last set; the counter never relies on wrapping.
  assign cnt_last = (flush_cnt == {INDEX_WIDTH{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      flush_pending <= 1'b0;
    end else begin
      state         <= state_n;
      flush_pending <= flush_pending_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= '0;
    end else if (state == ST_FLUSH) begin
      flush_cnt <= cnt_last ? '0 : flush_cnt + INDEX_WIDTH'(1);
    end
  end

  always_comb begin
    state_n       = state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    flush_busy    = 1'b0;
    flush_done    = 1'b0;
    multi_hit_err = 1'b0;
    accept        = 1'b0;
    in_select     = 1'b0;
    case (state)
      ST_IDLE: begin
        // Held low while in reset so every output reads 0.
        req_ready = rst_n && !flush_pending;
        if (req_valid && !flush_pending) begin
          accept  = 1'b1;
          state_n = ST_SELECT;
        end else if (flush_pending || flush_req) begin
          state_n = ST_FLUSH;
        end
      end
      ST_SELECT: begin
        in_select     = 1'b1;
        multi_hit_err = multi_hit;
        state_n       = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_n = ST_IDLE;
      end
      ST_FLUSH: begin
        flush_busy = 1'b1;
        if (cnt_last) begin
          flush_done = 1'b1;
          state_n    = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // A flush request seen while a request is in flight (including the very
  // cycle it is accepted) is remembered; requests during FLUSH are dropped.
  always_comb begin
    flush_pending_n = flush_pending;
    if (state == ST_FLUSH && cnt_last) begin
      flush_pending_n = 1'b0;
    end else if (flush_req && (state == ST_SELECT || state == ST_RESP || accept)) begin
      flush_pending_n = 1'b1;
    end
  end

  // ---- stage p0: capture the lookup result ----
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_p0   <= req_index;
      hit_p0   <= req_hit;
      valid_p0 <= req_valid_vec;
      dirty_p0 <= req_dirty_vec;
    end
  end

  l3_plru_ram #(
    .SETS   (SETS),
    .IDX_W  (INDEX_WIDTH),
    .DATA_W (PW)
  ) u_plru_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_idx  (idx_p0),
    .rd_data (plru_rd),
    .wr_en   (in_select),
    .wr_idx  (idx_p0),
    .wr_data (plru_wr),
    .clr_en  (flush_busy),
    .clr_idx (flush_cnt)
  );

  // ---- stage p1: select way, update PLRU, register the response ----
  always_comb begin
    hit_ext                 = '0;
    hit_ext[WAYS-1:0]       = hit_p0;
    free_ext                = '0;
    free_ext[WAYS-1:0]      = ~valid_p0;
    plru_ext                = '0;
    plru_ext[PW-1:0]        = plru_rd;
    hit_any                 = |hit_p0;
    multi_hit               = (hit_p0 & (hit_p0 - WAYS'(1))) != '0;
    if (hit_any) begin
      way_idx = lowest_set(hit_ext);
    end else if (!(&valid_p0)) begin
      way_idx = lowest_set(free_ext);
    end else begin
      way_idx = plru_victim(plru_ext, WAYS);
    end
    way_oh      = WAYS'(1) << way_idx;
    evict_dirty = !hit_any && ((valid_p0 & dirty_p0 & way_oh) != '0);
    // The chosen way always becomes most-recently-used, hit or fill.
    plru_wr     = PW'(plru_update(plru_ext, way_idx, WAYS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      way_p1      <= '0;
      hit_flag_p1 <= 1'b0;
      evict_p1    <= 1'b0;
    end else if (in_select) begin
      way_p1      <= way_oh;
      hit_flag_p1 <= hit_any;
      evict_p1    <= evict_dirty;
    end
  end

  assign resp_way         = way_p1;
  assign resp_hit         = hit_flag_p1;
  assign resp_evict_dirty = evict_p1;

endmodule

// File: tb/tb_l3_victim_select.sv
// ---------------------------------------------------------------------------
// tb_l3_victim_select
// Self-checking bench: directed cases with literal expectations, then random
// requests checked against a tree-PLRU model of every set.
// ---------------------------------------------------------------------------
module tb_l3_victim_select;

  localparam int WAYS = 16;
  localparam int IW   = 12;
  localparam int SETS = 4096;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [IW-1:0]   req_index = '0;
  logic [WAYS-1:0] req_hit = '0;
  logic [WAYS-1:0] req_valid_vec = '0;
  logic [WAYS-1:0] req_dirty_vec = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [WAYS-1:0] resp_way;
  logic            resp_hit;
  logic            resp_evict_dirty;
  logic            multi_hit_err;
  logic            flush_req = 1'b0;
  logic            flush_busy;
  logic            flush_done;

  always #5 clk = ~clk;

  l3_victim_select #(.WAYS(WAYS), .INDEX_WIDTH(IW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_index        (req_index),
    .req_hit          (req_hit),
    .req_valid_vec    (req_valid_vec),
    .req_dirty_vec    (req_dirty_vec),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_way         (resp_way),
    .resp_hit         (resp_hit),
    .resp_evict_dirty (resp_evict_dirty),
    .multi_hit_err    (multi_hit_err),
    .flush_req        (flush_req),
    .flush_busy       (flush_busy),
    .flush_done       (flush_done)
  );

  typedef struct packed {
    logic [WAYS-1:0] way;
    logic            hit;
    logic            evict;
  } exp_t;

  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  // tree[s][n] is PLRU node n (1..WAYS-1) of set s
  logic [WAYS-1:0] tree [SETS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    foreach (tree[i]) tree[i] = '0;
  endfunction

  task automatic model_req(input int idx, input logic [WAYS-1:0] h, input logic [WAYS-1:0] v,
                           input logic [WAYS-1:0] d, output exp_t e, output logic mhe);
    int way;
    int n;
    way = 0;
    if (h != 0) begin
      while (!h[way]) way++;
      e.hit = 1'b1;
    end else if (v != {WAYS{1'b1}}) begin
      while (v[way]) way++;
      e.hit = 1'b0;
    end else begin
      n = 1;
      while (n < WAYS) n = 2 * n + (tree[idx][n] ? 1 : 0);
      way   = n - WAYS;
      e.hit = 1'b0;
    end
    n = way + WAYS;
    while (n > 1) begin
      tree[idx][n / 2] = (n % 2 == 0);
      n = n / 2;
    end
    e.way   = WAYS'(1) << way;
    e.evict = !e.hit && v[way] && d[way];
    mhe     = ($countones(h) > 1);
  endtask

  // Every cycle a response is presented it must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL resp_unexpected: got resp_valid=1, expected no response (t=%0t)", $time);
      end else begin
        chk("resp_way", resp_way, exp_q[0].way);
        chk("resp_hit", resp_hit, exp_q[0].hit);
        chk("resp_evict_dirty", resp_evict_dirty, exp_q[0].evict);
      end
    end
  end

  task automatic send(input int idx, input logic [WAYS-1:0] h, input logic [WAYS-1:0] v,
                      input logic [WAYS-1:0] d, input int hold, input logic [WAYS-1:0] lit,
                      input bit fl, input bit abort);
    exp_t e;
    logic mhe;
    int   guard;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL req_ready_timeout: got req_ready=0 for 200 cycles, expected 1");
      return;
    end
    req_valid     = 1'b1;
    req_index     = IW'(idx);
    req_hit       = h;
    req_valid_vec = v;
    req_dirty_vec = d;
    model_req(idx, h, v, d, e, mhe);
    exp_q.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("multi_hit_err", multi_hit_err, mhe);
    chk("resp_valid_t1", resp_valid, 0);
    @(negedge clk);
    chk("resp_valid_t2", resp_valid, 1);
    if (lit != 0) chk("resp_way_literal", resp_way, lit);
    if (abort) begin
      rst_n = 1'b0;
      #1;
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      exp_q.delete();
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_req_ready", req_ready, 1);
      chk("post_rst_resp_valid", resp_valid, 0);
      return;
    end
    for (int k = 0; k < hold; k++) begin
      flush_req = fl && (k == 0);
      chk("hold_req_ready", req_ready, 0);
      @(negedge clk);
    end
    flush_req  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    void'(exp_q.pop_front());
  endtask

  task automatic wait_flush();
    int busy;
    int done;
    int done_at;
    int guard;
    busy = 0;
    done = 0;
    done_at = 0;
    guard = 0;
    @(negedge clk);
    while (flush_busy && guard < SETS + 100) begin
      busy++;
      if (flush_done) begin
        done++;
        done_at = busy;
      end
      if (busy == 3) flush_req = 1'b0;
      @(negedge clk);
      guard++;
    end
    flush_req = 1'b0;
    chk("flush_busy_cycles", busy, SETS);
    chk("flush_done_count", done, 1);
    chk("flush_done_last_cycle", done_at, SETS);
    @(negedge clk);
    chk("flush_no_retrigger", flush_busy, 0);
    chk("flush_idle_ready", req_ready, 1);
    model_clear();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion, expected $finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WAYS-1:0] h, v, d;
    int r;
    model_clear();
    repeat (2) @(negedge clk);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_resp_way", resp_way, 0);
    chk("reset_flush_busy", flush_busy, 0);
    chk("reset_flush_done", flush_done, 0);
    chk("reset_multi_hit_err", multi_hit_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", req_ready, 1);

    // PLRU rotation on one set
    send(5, 16'h0000, 16'hFFFF, 16'h0000, 0, 16'h0001, 0, 0);
    send(5, 16'h0000, 16'hFFFF, 16'h0000, 0, 16'h0100, 0, 0);
    send(5, 16'h0000, 16'hFFFF, 16'h0000, 0, 16'h0010, 0, 0);
    // hit on way 5 points the root right, so the next miss lands on way 8
    send(7, 16'h0020, 16'hFFFF, 16'h0000, 0, 16'h0020, 0, 0);
    send(7, 16'h0000, 16'hFFFF, 16'h0000, 0, 16'h0100, 0, 0);
    // invalid way, dirty victim, multi-hit
    send(10, 16'h0000, 16'hFFF7, 16'hFFFF, 0, 16'h0008, 0, 0);
    send(11, 16'h0000, 16'hFFFF, 16'h0001, 0, 16'h0001, 0, 0);
    send(12, 16'h0011, 16'hFFFF, 16'h0000, 0, 16'h0001, 0, 0);

    // backpressure with a flush request arriving during RESP
    send(20, 16'h0000, 16'hFFFF, 16'hFFFF, 5, 16'h0001, 1, 0);
    @(negedge clk);
    chk("pending_blocks_req", req_ready, 0);
    chk("flush_after_handshake", flush_busy, 0);
    wait_flush();

    // flush from IDLE, flush_req held into FLUSH
    @(negedge clk);
    flush_req = 1'b1;
    wait_flush();
    send(5, 16'h0000, 16'hFFFF, 16'h0000, 0, 16'h0001, 0, 0);

    // random traffic on a few sets so PLRU state gets reused
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) h = '0;
      else if (r < 9) h = WAYS'(1) << $urandom_range(0, WAYS - 1);
      else h = (WAYS'(1) << $urandom_range(0, WAYS - 1)) | (WAYS'(1) << $urandom_range(0, WAYS - 1));
      v = ($urandom_range(0, 3) == 0) ? WAYS'($urandom) : {WAYS{1'b1}};
      d = WAYS'($urandom);
      send($urandom_range(0, 7), h, v, d, $urandom_range(0, 2), '0, 0, 0);
    end

    // reset while a response is pending
    send(3, 16'h0000, 16'hFFFF, 16'h0000, 1, 16'h0000, 0, 1);
    send(5, 16'h0000, 16'hFFFF, 16'h0000, 0, 16'h0001, 0, 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
